// File: rtl/servo_pkg.sv
// Shared constants for the servo PWM block.
// Holds the default timing parameters and the position width. Both
// servo_pwm and tick_gen import this package.
package servo_pkg;

  // Default timing: a 12 MHz clk gives 1 us ticks, a 20 ms frame and
  // pulses of 1.0 ms to 2.02 ms.
  localparam int DIV_DEF         = 12;
  localparam int FRAME_TICKS_DEF = 20000;
  localparam int MIN_TICKS_DEF   = 1000;
  localparam int STEP_TICKS_DEF  = 4;

  // Width of a servo position command.
  localparam int POS_W = 8;

  // Largest position value the input port can carry.
  localparam int POS_MAX = (1 << POS_W) - 1;

endpackage : servo_pkg

// File: rtl/servo_tick_gen.sv
// Prescaler that sets the time base for the servo PWM.
// It counts 0..DIV-1 on clk. tick is high for the single clk in which
// the count is at DIV-1, so the wrap to 0 and every tick-driven update
// in the parent happen on the same edge.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset (count returns to 0)
//   tick - one-clk pulse once every DIV clks
module tick_gen #(
  parameter int DIV = servo_pkg::DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // the pre-edge values, whatever order the always blocks run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule : tick_gen

// File: rtl/servo_pwm.sv
// Hobby-servo PWM generator with a valid/ready position input.
// A frame lasts FRAME_TICKS ticks. The pulse at the start of each frame
// lasts MIN_TICKS + pos*STEP_TICKS ticks. An accepted position waits in
// a one-entry pending register and is loaded at the next frame boundary,
// so the pulse width never changes in the middle of a frame.
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-high reset
//   pos_data    - requested position, 0..255
//   pos_valid   - pos_data is valid
//   pos_ready   - high while no position is pending
//   servo_out   - registered PWM drive
//   frame_start - registered one-clk pulse in the first cycle of a frame
module servo_pwm
  import servo_pkg::*;
#(
  parameter int DIV         = DIV_DEF,
  parameter int FRAME_TICKS = FRAME_TICKS_DEF,
  parameter int MIN_TICKS   = MIN_TICKS_DEF,
  parameter int STEP_TICKS  = STEP_TICKS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] pos_data,
  input  logic             pos_valid,
  output logic             pos_ready,
  output logic             servo_out,
  output logic             frame_start
);

  // One extra bit so that MIN + pos*STEP never truncates before the compare.
  localparam int TW = $clog2(FRAME_TICKS) + 1;

  // The widest pulse must end inside the frame, and the prescaler needs
  // at least two states.
  if ((MIN_TICKS + POS_MAX * STEP_TICKS >= FRAME_TICKS) || (DIV < 2)) begin : g_param_check
    $error("servo_pwm: need MIN_TICKS + 255*STEP_TICKS < FRAME_TICKS and DIV >= 2");
  end

  logic             tick;
  logic [TW-1:0]    tcnt;
  logic [TW-1:0]    tcnt_nxt;
  logic [TW-1:0]    pulse_nxt;
  logic [POS_W-1:0] active_pos;
  logic [POS_W-1:0] active_nxt;
  logic [POS_W-1:0] pend_pos;
  logic             pending;
  logic             enabled;
  logic             enabled_nxt;
  logic             boundary;
  logic             load;
  logic             accept;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // pos_ready comes only from a flop, so there is no combinational path
  // from pos_valid to pos_ready.
  assign pos_ready = !pending;
  assign accept    = pos_valid && pos_ready;
  assign boundary  = tick && (tcnt == TW'(FRAME_TICKS - 1));
  assign load      = boundary && pending;

  // The values that tcnt and the active position take at the next tick.
  // servo_out is computed from these values, so it lines up with tcnt.
  // NOTE: every always_comb output gets a default on the first line, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    tcnt_nxt    = tcnt + TW'(1);
    active_nxt  = active_pos;
    enabled_nxt = enabled;
    if (boundary) begin
      tcnt_nxt = '0;
    end
    if (load) begin
      active_nxt  = pend_pos;
      enabled_nxt = 1'b1;
    end
    pulse_nxt = TW'(MIN_TICKS) + TW'(active_nxt) * TW'(STEP_TICKS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt        <= '0;
      active_pos  <= '0;
      enabled     <= 1'b0;
      servo_out   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (tick) begin
        tcnt       <= tcnt_nxt;
        active_pos <= active_nxt;
        enabled    <= enabled_nxt;
        servo_out  <= enabled_nxt && (tcnt_nxt < pulse_nxt);
      end
    end
  end

  // Pending slot. A boundary load and a new transfer never coincide,
  // because a transfer needs pending clear and a load needs it set.
  // A transfer in a boundary cycle therefore waits for the next boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= 1'b0;
      pend_pos <= '0;
    end else if (load) begin
      pending <= 1'b0;
    end else if (accept) begin
      pending  <= 1'b1;
      pend_pos <= pos_data;
    end
  end

endmodule : servo_pwm

// File: tb/tb_servo_pwm.sv
// Directed bench for servo_pwm with DIV=2, FRAME_TICKS=300, MIN_TICKS=10,
// STEP_TICKS=1, so one frame is 600 clk and a position p gives a pulse
// of 2*(10+p) clk. Outputs are sampled on the falling edge.
module tb_servo_pwm;

  localparam int DIV         = 2;
  localparam int FRAME_TICKS = 300;
  localparam int MIN_TICKS   = 10;
  localparam int STEP_TICKS  = 1;
  localparam int FRAME_CLK   = DIV * FRAME_TICKS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pos_data = 8'd0;
  logic       pos_valid = 1'b0;
  logic       pos_ready;
  logic       servo_out;
  logic       frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  servo_pwm #(
    .DIV         (DIV),
    .FRAME_TICKS (FRAME_TICKS),
    .MIN_TICKS   (MIN_TICKS),
    .STEP_TICKS  (STEP_TICKS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pos_data    (pos_data),
    .pos_valid   (pos_valid),
    .pos_ready   (pos_ready),
    .servo_out   (servo_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // High-time in clk cycles for position p.
  function automatic int pulse_clk(input int p);
    return DIV * (MIN_TICKS + p * STEP_TICKS);
  endfunction

  // Advances to the next frame_start cycle, giving up after 2000 clk.
  task automatic wait_fs(input string tag);
    int waited = 0;
    while (frame_start !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check(tag, frame_start, 1'b1);
  endtask

  // Observes one frame, starting in its frame_start cycle and ending at
  // the negedge of the next one. Up to two one-cycle transfers are driven
  // at iterations s1 and s2 (-1 means none).
  task automatic check_frame(input string tag, input int exp_high, input int exp_ready_low,
                             input int s1, input logic [7:0] p1,
                             input int s2, input logic [7:0] p2);
    int   high = 0;
    int   rises = 0;
    int   fs_cnt = 0;
    int   ready_low = 0;
    logic prev = 1'b0;
    check({tag, "_fs_at_start"}, frame_start, 1'b1);
    for (int i = 0; i < FRAME_CLK; i++) begin
      if (servo_out === 1'b1) high++;
      if (servo_out === 1'b1 && prev !== 1'b1) rises++;
      if (frame_start === 1'b1) fs_cnt++;
      if (pos_ready !== 1'b1) ready_low++;
      prev = servo_out;
      if (i == s1) begin
        pos_valid = 1'b1;
        pos_data  = p1;
      end else if (i == s2) begin
        pos_valid = 1'b1;
        pos_data  = p2;
      end
      @(negedge clk);
      pos_valid = 1'b0;
      pos_data  = 8'd0;
    end
    check({tag, "_high_clk"}, high, exp_high);
    check({tag, "_rises"}, rises, (exp_high > 0) ? 1 : 0);
    check({tag, "_fs_count"}, fs_cnt, 1);
    check({tag, "_ready_low"}, ready_low, exp_ready_low);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_servo_out", servo_out, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_pos_ready", pos_ready, 1'b1);
    rst = 1'b0;

    // Idle: three frames without a transfer, 600 clk apart
    wait_fs("idle_first_fs");
    check_frame("idle0", 0, 0, -1, 8'd0, -1, 8'd0);
    check_frame("idle1", 0, 0, -1, 8'd0, -1, 8'd0);
    check_frame("idle2", 0, 0, -1, 8'd0, -1, 8'd0);

    // pos 20, accepted at iteration 100: ready is low for 101..599,
    // then pulses of 60 clk begin at the next frame
    check_frame("send20", 0, FRAME_CLK - 101, 100, 8'd20, -1, 8'd0);
    check_frame("pos20", pulse_clk(20), 0, -1, 8'd0, -1, 8'd0);

    // 255 then 0 in successive frames; each takes effect only at a boundary
    check_frame("send255", pulse_clk(20), FRAME_CLK - 51, 50, 8'd255, -1, 8'd0);
    check_frame("pos255", pulse_clk(255), FRAME_CLK - 51, 50, 8'd0, -1, 8'd0);
    check_frame("pos0", pulse_clk(0), 0, -1, 8'd0, -1, 8'd0);

    // pos 5 sent in the boundary cycle: the next frame keeps width 0,
    // and the frame after it uses 15 ticks
    check_frame("send5_bnd", pulse_clk(0), 0, FRAME_CLK - 1, 8'd5, -1, 8'd0);
    check_frame("hold_old", pulse_clk(0), FRAME_CLK, -1, 8'd0, -1, 8'd0);
    check_frame("pos5", pulse_clk(5), 0, -1, 8'd0, -1, 8'd0);

    // pos 40 accepted, then pos 60 offered while pending and ignored
    check_frame("send40_60", pulse_clk(5), FRAME_CLK - 11, 10, 8'd40, 20, 8'd60);
    check_frame("pos40", pulse_clk(40), 0, -1, 8'd0, -1, 8'd0);

    // Reset in the middle of a pulse
    repeat (10) @(negedge clk);
    check("pre_rst_servo_high", servo_out, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_servo_out", servo_out, 1'b0);
    check("midrst_frame_start", frame_start, 1'b0);
    check("midrst_pos_ready", pos_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    wait_fs("postrst_first_fs");
    check_frame("postrst0", 0, 0, -1, 8'd0, -1, 8'd0);
    check_frame("postrst1", 0, 0, -1, 8'd0, -1, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_servo_pwm
